capture_arbiter: RTL and testbench

- Round-robin arbiter that shares one DATA_W-bit capture register (q, clocked on posedge clk) between N_REQ requesters.
- Each grant loads the winning requester's data into q.
- After each grant, q is held stable for a programmable number of cycles so downstream samplers get a guaranteed setup/hold window.
- Sits between bench/driver-side requesters and the sampled register stage.

---
 rtl/capture_arb_pkg.sv | 19 +
 rtl/capture_arb_rr_pick.sv | 29 ++
 rtl/capture_arbiter.sv | 110 +++++++++++
 tb/tb_capture_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/capture_arb_pkg.sv
// Shared types and helpers for the capture arbiter.
// Optional lock support is enabled by defining CAPTURE_ARB_LOCK_EN.
package capture_arb_pkg;

   typedef enum logic {IDLE, HOLD} state_t;

   // Index width with a 1-bit floor so degenerate sizes still get a real vector.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] onehot(input int idx, input int n);
      logic [31:0] r;
      r = '0;
      if (idx >= 0 && idx < n && idx < 32) r = 32'd1 << idx;
      return r;
   endfunction

endpackage

// File: rtl/capture_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of ereq at or above ptr, wrapping.
module capture_arb_rr_pick
   import capture_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] ereq,
   input  logic [IW-1:0]    ptr,
   output logic             any,
   output logic [IW-1:0]    w
);

   // Scan offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      any = 1'b0;
      w   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         int idx;
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (ereq[idx[IW-1:0]]) begin
            any = 1'b1;
            w   = idx[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/capture_arbiter.sv
// Round-robin arbiter sharing one capture register, with a post-grant hold window.
// Define CAPTURE_ARB_LOCK_EN to add the lock port (winner keeps top priority).
module capture_arbiter
   import capture_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = 8,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ-1:0][DATA_W-1:0] data,
`ifdef CAPTURE_ARB_LOCK_EN
   input  logic [N_REQ-1:0]             lock,
`endif
   output logic [N_REQ-1:0]             gnt,
   output logic [DATA_W-1:0]            q,
   output logic                         q_valid,
   output logic [idx_w(N_REQ)-1:0]      q_src,
   output logic                         busy
);

   localparam int IW = idx_w(N_REQ);
   localparam int CW = idx_w(HOLD_CYCLES + 1);

   state_t             state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [IW-1:0]      ptr, ptr_n;
   logic [N_REQ-1:0]   gnt_n;
   logic [DATA_W-1:0]  q_n;
   logic               q_valid_n;
   logic [IW-1:0]      q_src_n;
   logic               busy_n;
   logic [N_REQ-1:0]   ereq;
   logic               any;
   logic [IW-1:0]      w;

   // Last cycle's winner may still show req while it drops it; never re-grant it.
   assign ereq = req & ~gnt;

   capture_arb_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .ereq (ereq),
      .ptr  (ptr),
      .any  (any),
      .w    (w)
   );

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      ptr_n     = ptr;
      gnt_n     = '0;
      q_n       = q;
      q_valid_n = 1'b0;
      q_src_n   = q_src;
      busy_n    = busy;
      case (state)
         IDLE: begin
            if (any) begin
               q_n       = data[w];
               q_src_n   = w;
               gnt_n     = N_REQ'(onehot(int'(w), N_REQ));
               q_valid_n = 1'b1;
               ptr_n     = (int'(w) == N_REQ - 1) ? '0 : w + 1'b1;
`ifdef CAPTURE_ARB_LOCK_EN
               if (lock[w]) ptr_n = w;
`endif
               if (HOLD_CYCLES > 0) begin
                  state_n = HOLD;
                  cnt_n   = CW'(HOLD_CYCLES - 1);
                  busy_n  = 1'b1;
               end
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         ptr     <= '0;
         gnt     <= '0;
         q       <= '0;
         q_valid <= 1'b0;
         q_src   <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         ptr     <= ptr_n;
         gnt     <= gnt_n;
         q       <= q_n;
         q_valid <= q_valid_n;
         q_src   <= q_src_n;
         busy    <= busy_n;
      end
   end

endmodule

// File: tb/tb_capture_arbiter.sv
// Scoreboard bench for capture_arbiter: expected grants queued by stimulus, checked by monitors.
module tb_capture_arbiter;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       req_a, req_b, gnt_a, gnt_b;
   logic [3:0][7:0]  data_a, data_b;
   logic [7:0]       q_a, q_b;
   logic             qv_a, qv_b, busy_a, busy_b;
   logic [1:0]       src_a, src_b;
`ifdef CAPTURE_ARB_LOCK_EN
   logic [3:0]       lock_a, lock_b;
`endif

   typedef struct {
      int         src;
      logic [7:0] d;
      int         cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   bit   done = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   capture_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .data(data_a),
`ifdef CAPTURE_ARB_LOCK_EN
      .lock(lock_a),
`endif
      .gnt(gnt_a), .q(q_a), .q_valid(qv_a), .q_src(src_a), .busy(busy_a)
   );

   capture_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .data(data_b),
`ifdef CAPTURE_ARB_LOCK_EN
      .lock(lock_b),
`endif
      .gnt(gnt_b), .q(q_b), .q_valid(qv_b), .q_src(src_b), .busy(busy_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_a(input int src, input logic [7:0] d, input int c);
      exp_t e;
      e.src = src; e.d = d; e.cyc = c;
      qa.push_back(e);
   endtask

   task automatic push_b(input int src, input logic [7:0] d, input int c);
      exp_t e;
      e.src = src; e.d = d; e.cyc = c;
      qb.push_back(e);
   endtask

   // Monitors: any grant or q_valid pops one expectation and compares all fields.
   always @(negedge clk) begin
      if (!done && (qv_a || gnt_a != 4'b0)) begin
         n_chk++;
         if (qa.size() == 0) begin
            n_err++;
            $display("FAIL grant_a: unexpected gnt=%b q=%h src=%0d at cycle %0d", gnt_a, q_a, src_a, cyc);
         end else begin
            exp_t e;
            e = qa.pop_front();
            if (gnt_a !== (4'b1 << e.src) || !qv_a || q_a !== e.d || int'(src_a) != e.src || cyc != e.cyc) begin
               n_err++;
               $display("FAIL grant_a: gnt=%b qv=%b q=%h src=%0d cyc=%0d, expected gnt=%b qv=1 q=%h src=%0d cyc=%0d",
                        gnt_a, qv_a, q_a, src_a, cyc, 4'b1 << e.src, e.d, e.src, e.cyc);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!done && (qv_b || gnt_b != 4'b0)) begin
         n_chk++;
         if (qb.size() == 0) begin
            n_err++;
            $display("FAIL grant_b: unexpected gnt=%b q=%h src=%0d at cycle %0d", gnt_b, q_b, src_b, cyc);
         end else begin
            exp_t e;
            e = qb.pop_front();
            if (gnt_b !== (4'b1 << e.src) || !qv_b || q_b !== e.d || int'(src_b) != e.src || cyc != e.cyc) begin
               n_err++;
               $display("FAIL grant_b: gnt=%b qv=%b q=%h src=%0d cyc=%0d, expected gnt=%b qv=1 q=%h src=%0d cyc=%0d",
                        gnt_b, qv_b, q_b, src_b, cyc, 4'b1 << e.src, e.d, e.src, e.cyc);
            end
         end
      end
   end

   initial begin
      rst    = 1'b1;
      req_a  = 4'b1111;
      req_b  = 4'b0000;
      data_a = {8'd4, 8'd3, 8'd2, 8'd1};
      data_b = '0;
`ifdef CAPTURE_ARB_LOCK_EN
      lock_a = 4'b0;
      lock_b = 4'b0;
`endif
      // Reset held for two edges with every request asserted.
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_gnt", 32'(gnt_a), 32'h0);
         chk("rst_q", 32'(q_a), 32'h0);
         chk("rst_qv", 32'(qv_a), 32'h0);
         chk("rst_busy", 32'(busy_a), 32'h0);
      end

      // Full contention: rotation 0,1,2,3,0 three cycles apart.
      rst = 1'b0;
      for (int i = 0; i < 5; i++) push_a(i % 4, 8'((i % 4) + 1), cyc + 1 + 3 * i);
      tick();
      chk("busy_g1_0", 32'(busy_a), 32'h1);
      tick();
      chk("busy_g1_1", 32'(busy_a), 32'h1);
      tick();
      chk("busy_g1_2", 32'(busy_a), 32'h0);
      repeat (10) tick();
      req_a = 4'b0;
      repeat (3) tick();

      // Single requester 2.
      data_a[2] = 8'hA5;
      req_a = 4'b0100;
      push_a(2, 8'hA5, cyc + 1);
      tick();
      req_a = 4'b0;
      chk("single_busy0", 32'(busy_a), 32'h1);
      tick();
      chk("single_busy1", 32'(busy_a), 32'h1);
      chk("single_gnt_hold", 32'(gnt_a), 32'h0);
      tick();
      chk("single_busy2", 32'(busy_a), 32'h0);
      repeat (3) tick();
      chk("single_q_stable", 32'(q_a), 32'hA5);
      chk("single_src_stable", 32'(src_a), 32'h2);

      // Reset in the middle of a hold; ptr returns to 0.
      data_a[1] = 8'h55;
      req_a = 4'b0010;
      push_a(1, 8'h55, cyc + 1);
      tick();
      rst = 1'b1;
      req_a = 4'b0;
      tick();
      chk("midrst_busy", 32'(busy_a), 32'h0);
      chk("midrst_gnt", 32'(gnt_a), 32'h0);
      chk("midrst_q", 32'(q_a), 32'h0);
      chk("midrst_src", 32'(src_a), 32'h0);
      rst = 1'b0;
      data_a[1] = 8'h66;
      data_a[3] = 8'h77;
      req_a = 4'b1010;
      push_a(1, 8'h66, cyc + 1);
      tick();
      req_a = 4'b0;
      repeat (3) tick();

      // HOLD_CYCLES=0: back-to-back grants, winner masked the cycle after.
      data_b[0] = 8'h10;
      data_b[1] = 8'h20;
      req_b = 4'b0011;
      push_b(0, 8'h10, cyc + 1);
      push_b(1, 8'h20, cyc + 2);
      tick();
      req_b = 4'b0010;
      chk("b_busy", 32'(busy_b), 32'h0);
      tick();
      req_b = 4'b0;
      repeat (2) tick();
      // A lone requester that holds req is granted every other cycle.
      req_b = 4'b0001;
      push_b(0, 8'h10, cyc + 1);
      push_b(0, 8'h10, cyc + 3);
      repeat (3) tick();
      req_b = 4'b0;
      repeat (2) tick();

`ifdef CAPTURE_ARB_LOCK_EN
      // Lock keeps requester 2 on top until released.
      data_a[2] = 8'hC2;
      data_a[3] = 8'hD3;
      lock_a = 4'b0100;
      req_a = 4'b1100;
      push_a(2, 8'hC2, cyc + 1);
      push_a(2, 8'hC2, cyc + 4);
      push_a(2, 8'hC2, cyc + 7);
      push_a(3, 8'hD3, cyc + 10);
      repeat (4) tick();
      lock_a = 4'b0;
      repeat (6) tick();
      req_a = 4'b0;
      repeat (4) tick();
`endif

      repeat (4) tick();
      chk("a_queue_drained", 32'(qa.size()), 32'h0);
      chk("b_queue_drained", 32'(qb.size()), 32'h0);
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
